// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial 3-digit BCD adder, one decade per clock, with start/busy/done handshake.
module bcd_serial_adder #(
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] x_ones,
    input  logic [3:0] x_tens,
    input  logic [3:0] x_huns,
    input  logic [3:0] y_ones,
    input  logic [3:0] y_tens,
    input  logic [3:0] y_huns,
    output logic       busy,
    output logic       done,
    output logic [3:0] out_ones,
    output logic [3:0] out_tens,
    output logic [3:0] out_huns,
    output logic [3:0] out_thou,
    output logic       err
);
    typedef enum logic [2:0] {S_IDLE, S_ONES, S_TENS, S_HUNS, S_DONE} state_t;
    state_t     r_state;
    logic [3:0] r_xo, r_xt, r_xh, r_yo, r_yt, r_yh;
    logic [3:0] r_ones, r_tens, r_huns, r_thou;
    logic       r_carry, r_busy, r_done, r_err;
    logic [3:0] w_xd, w_yd, w_digit;
    logic [4:0] w_sum, w_adj;
    logic       w_hi, w_bad;
    always_comb begin
        w_xd    = r_state == S_ONES ? r_xo : r_state == S_TENS ? r_xt : r_xh;
        w_yd    = r_state == S_ONES ? r_yo : r_state == S_TENS ? r_yt : r_yh;
        w_sum   = {1'b0, w_xd} + {1'b0, w_yd} + {4'd0, r_carry};
        w_adj   = w_sum + 5'd6;
        w_hi    = w_sum > 5'd9;
        w_digit = w_hi ? w_adj[3:0] : w_sum[3:0];
        w_bad   = (x_ones > 4'd9) | (x_tens > 4'd9) | (x_huns > 4'd9) |
                  (y_ones > 4'd9) | (y_tens > 4'd9) | (y_huns > 4'd9);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            {r_xo, r_xt, r_xh, r_yo, r_yt, r_yh} <= '0;
            {r_ones, r_tens, r_huns, r_thou} <= '0;
            {r_carry, r_busy, r_done, r_err} <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        {r_xo, r_xt, r_xh} <= {x_ones, x_tens, x_huns};
                        {r_yo, r_yt, r_yh} <= {y_ones, y_tens, y_huns};
                        r_err   <= w_bad;
                        r_carry <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_ONES;
                    end else if (r_state == S_DONE && !DONE_HOLD) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ONES: begin
                    r_ones  <= w_digit;
                    r_carry <= w_hi;
                    r_state <= S_TENS;
                end
                S_TENS: begin
                    r_tens  <= w_digit;
                    r_carry <= w_hi;
                    r_state <= S_HUNS;
                end
                S_HUNS: begin
                    // invalid operands still take the full sequence, but report a zero result
                    r_ones  <= r_err ? 4'd0 : r_ones;
                    r_tens  <= r_err ? 4'd0 : r_tens;
                    r_huns  <= r_err ? 4'd0 : w_digit;
                    r_thou  <= r_err ? 4'd0 : {3'b000, w_hi};
                    r_carry <= w_hi;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign out_ones = r_ones;
    assign out_tens = r_tens;
    assign out_huns = r_huns;
    assign out_thou = r_thou;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: randomized self-checking bench for both DONE_HOLD settings against a decimal model.
module tb_bcd_serial_adder;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0] x_ones = '0, x_tens = '0, x_huns = '0, y_ones = '0, y_tens = '0, y_huns = '0;
    logic       busy0, done0, err0, busy1, done1, err1;
    logic [3:0] oo0, ot0, oh0, oth0, oo1, ot1, oh1, oth1;
    int         n_tests = 0, n_fail = 0;

    bcd_serial_adder #(.DONE_HOLD(1'b0)) u_pulse (
        .clk(clk), .rst(rst), .start(start),
        .x_ones(x_ones), .x_tens(x_tens), .x_huns(x_huns),
        .y_ones(y_ones), .y_tens(y_tens), .y_huns(y_huns),
        .busy(busy0), .done(done0),
        .out_ones(oo0), .out_tens(ot0), .out_huns(oh0), .out_thou(oth0), .err(err0));

    bcd_serial_adder #(.DONE_HOLD(1'b1)) u_hold (
        .clk(clk), .rst(rst), .start(start),
        .x_ones(x_ones), .x_tens(x_tens), .x_huns(x_huns),
        .y_ones(y_ones), .y_tens(y_tens), .y_huns(y_huns),
        .busy(busy1), .done(done1),
        .out_ones(oo1), .out_tens(ot1), .out_huns(oh1), .out_thou(oth1), .err(err1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input int th, input int h, input int t, input int o, input bit e);
        check({tag, " p.thou"}, oth0, th); check({tag, " p.huns"}, oh0, h);
        check({tag, " p.tens"}, ot0, t);   check({tag, " p.ones"}, oo0, o);
        check({tag, " p.err"}, err0, e);
        check({tag, " h.thou"}, oth1, th); check({tag, " h.huns"}, oh1, h);
        check({tag, " h.tens"}, ot1, t);   check({tag, " h.ones"}, oo1, o);
        check({tag, " h.err"}, err1, e);
    endtask

    task automatic step(input string tag, input bit b, input bit d0, input bit d1);
        @(posedge clk); #1;
        check({tag, " p.busy"}, busy0, b); check({tag, " h.busy"}, busy1, b);
        check({tag, " p.done"}, done0, d0); check({tag, " h.done"}, done1, d1);
    endtask

    function automatic logic [3:0] rd();
        return 4'($urandom_range(9, 0));
    endfunction

    task automatic set_ops(input logic [3:0] xo, xt, xh, yo, yt, yh);
        {x_ones, x_tens, x_huns, y_ones, y_tens, y_huns} = {xo, xt, xh, yo, yt, yh};
    endtask

    // decimal reference: plain integer sum split into decimal digits
    task automatic model(input logic [3:0] xo, xt, xh, yo, yt, yh,
                         output int th, output int h, output int t, output int o, output bit e);
        int s;
        e = (xo > 9) || (xt > 9) || (xh > 9) || (yo > 9) || (yt > 9) || (yh > 9);
        s = (xh * 100 + xt * 10 + xo) + (yh * 100 + yt * 10 + yo);
        th = e ? 0 : s / 1000;
        h  = e ? 0 : (s / 100) % 10;
        t  = e ? 0 : (s / 10) % 10;
        o  = e ? 0 : s % 10;
    endtask

    task automatic run_op(input string tag, input logic [3:0] xo, xt, xh, yo, yt, yh, input bit spam);
        int th, h, t, o;
        bit e;
        model(xo, xt, xh, yo, yt, yh, th, h, t, o, e);
        @(negedge clk); set_ops(xo, xt, xh, yo, yt, yh); start = 1'b1;
        step({tag, " acc"}, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = spam;
            set_ops(rd(), rd(), rd(), rd(), rd(), rd());
            step({tag, " busy"}, 1, 0, 0);
        end
        @(negedge clk); start = 1'b0; set_ops(rd(), rd(), rd(), rd(), rd(), rd());
        step({tag, " done"}, 0, 1, 1);
        check_res({tag, " res"}, th, h, t, o, e);
        step({tag, " after"}, 0, 0, 1);
        check_res({tag, " hold"}, th, h, t, o, e);
    endtask

    initial begin
        int th, h, t, o;
        bit e;
        logic [3:0] d [6];
        repeat (2) @(posedge clk);
        #1;
        check_res("reset", 0, 0, 0, 0, 0);
        check("reset p.busy", busy0, 0); check("reset p.done", done0, 0);
        check("reset h.busy", busy1, 0); check("reset h.done", done1, 0);
        @(negedge clk); rst = 1'b0;

        run_op("123+456", 4'd3, 4'd2, 4'd1, 4'd6, 4'd5, 4'd4, 0);
        run_op("999+999", 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 0);
        run_op("005+005", 4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 0);
        run_op("badA+001", 4'hA, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 0);
        run_op("001+001", 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 0);
        run_op("spam", 4'd7, 4'd8, 4'd2, 4'd6, 4'd4, 4'd3, 1);

        @(negedge clk); set_ops(4'd9, 4'd9, 4'd9, 4'd1, 4'd0, 4'd0); start = 1'b1;
        step("mid acc", 1, 0, 0);
        @(negedge clk); start = 1'b0;
        step("mid ones", 1, 0, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_res("mid rst", 0, 0, 0, 0, 0);
        check("mid rst p.busy", busy0, 0); check("mid rst h.busy", busy1, 0);
        check("mid rst p.done", done0, 0); check("mid rst h.done", done1, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) step("mid quiet", 0, 0, 0);
        run_op("post rst", 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 6; i++) d[i] = rd();
            model(d[0], d[1], d[2], d[3], d[4], d[5], th, h, t, o, e);
            @(negedge clk); set_ops(d[0], d[1], d[2], d[3], d[4], d[5]); start = 1'b1;
            step("b2b acc", 1, 0, 0);
            step("b2b busy", 1, 0, 0);
            step("b2b busy", 1, 0, 0);
            step("b2b done", 0, 1, 1);
            check_res("b2b res", th, h, t, o, e);
        end
        @(negedge clk); start = 1'b0;
        step("b2b tail", 0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 6; i++)
                d[i] = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 10)) : rd();
            run_op("rand", d[0], d[1], d[2], d[3], d[4], d[5], bit'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Digit-serial, 3-digit unsigned BCD adder; the additive counterpart to the team's BCD subtractor.
- Operands use the same ones/tens/huns digit-port layout as the subtractor.
- Processes one decade per clock (ones, then tens, then huns) with a registered decimal carry.
- Produces a registered 4-digit BCD result (0000..1998) with start/busy/done handshake and a digit-validity error flag.

Parameters:
DONE_HOLD, 0, 0: done is a single-cycle pulse; 1: done stays high until the next accepted start or reset.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when not busy
x_ones  in  4  operand X ones digit (BCD)
x_tens  in  4  operand X tens digit
x_huns  in  4  operand X hundreds digit
y_ones  in  4  operand Y ones digit
y_tens  in  4  operand Y tens digit
y_huns  in  4  operand Y hundreds digit
busy  out  1  high while a sum is in progress
done  out  1  result valid strobe (see DONE_HOLD)
out_ones  out  4  sum ones digit
out_tens  out  4  sum tens digit
out_huns  out  4  sum hundreds digit
out_thou  out  4  sum thousands digit (0 or 1)
err  out  1  operand contained a non-BCD digit (>9)

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE; busy=0, done=0, err=0; out_* = 4'd0; internal carry=0, operand registers=0. rst has priority over every other input.
- States: IDLE, ONES, TENS, HUNS, DONE.
- IDLE/DONE + start=1 at edge k:
  - Latch all six digits.
  - err <= 1 if any latched digit >9, else 0.
  - carry <= 0; busy <= 1; done <= 0; next state=ONES.
- IDLE/DONE + start=0: stay. In DONE with DONE_HOLD=0, done drops after one cycle and state returns to IDLE. With DONE_HOLD=1, state remains DONE and done stays high.
- ONES (edge k+1), TENS (edge k+2), HUNS (edge k+3) digit step:
  - s = xd + yd + carry, 5-bit.
  - If s>9: digit = (s+6)[3:0], carry <= 1; else digit = s[3:0], carry <= 0.
  - Digit written to the matching out_ register.
- At edge k+3 also: out_thou <= {3'b0, carry_from_huns}; busy <= 0; done <= 1; state=DONE.
- Latency: start sampled at edge k, done high in the cycle after edge k+3 (4 clocks). busy is high in the three cycles after edges k..k+2.
- Invalid digits (err=1): the sequencer still runs the full 4 clocks so timing is identical. At edge k+3, all out_* are forced to 0 instead of the computed digits; done still asserts.
- start while busy: ignored; latched operands unchanged.
- Back-to-back: start=1 in the DONE cycle is accepted. done falls at that edge, and out_* hold the old result until overwritten digit by digit.
- out_* change only at digit-step edges, completion, or reset. Consumers read them only when done=1.
- Operand inputs need to be stable only at the start edge.
- Reset mid-operation: abort immediately; no done pulse; outputs zeroed.
- Max sum 999+999=1998, so no overflow beyond out_thou.

Test Plan:
1. rst, then start with X=123, Y=456 -> 4 clocks later done=1, out=0,5,7,9 (thou..ones), err=0, busy high for exactly 3 cycles.
2. X=999, Y=999 -> out_thou=1, huns=9, tens=9, ones=8 (1998); X=005, Y=005 -> 0,0,1,0 (ripple carry ones->tens).
3. X ones=4'hA, Y=001 -> done after 4 clocks with err=1, all out_*=0. A following valid start (X=001, Y=001) -> err=0, out=0002.
4. Pulse start again at cycles 1 and 2 of an active op with different operands -> ignored; result matches the first operands; exactly one done.
5. Assert rst in the TENS cycle -> busy=0, done never pulses, out_*=0. A new start then completes normally.
6. DONE_HOLD=0 vs 1 with start held high continuously -> DONE_HOLD=0: done pulses every 4th cycle with back-to-back results; DONE_HOLD=1: done stays high until the next start edge.
